// File: rtl/cpu_pkg.sv
// Shared CPU datapath widths and types.
package cpu_pkg;

  localparam int CPU_DATA_W   = 32;
  localparam int CPU_ADDR_W   = 5;
  localparam int CPU_NUM_REGS = 32;

  typedef logic [CPU_DATA_W-1:0] cpu_data_t;
  typedef logic [CPU_ADDR_W-1:0] cpu_regaddr_t;

endpackage

// File: rtl/reg_file_rd_port.sv
// One registered read port: range check, write-first bypass, enabled output register.
// REG_FILE_ZERO_REG_EN forces reads of address 0 to return zero, bypass included.
module reg_file_rd_port
  import cpu_pkg::*;
#(
  parameter int DATA_W   = CPU_DATA_W,
  parameter int ADDR_W   = CPU_ADDR_W,
  parameter int NUM_REGS = CPU_NUM_REGS
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ren_i,
  input  logic [ADDR_W-1:0] raddr_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] mem_i [NUM_REGS],
  output logic [DATA_W-1:0] dout_o
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic              in_range;
  logic              is_zero;
  logic              byp_hit;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] dout_d;
  logic [DATA_W-1:0] dout_q;

  always_comb begin
    in_range = (32'(raddr_i) < NUM_REGS);
`ifdef REG_FILE_ZERO_REG_EN
    is_zero  = (raddr_i == '0);
`else
    is_zero  = 1'b0;
`endif
    byp_hit  = we_i && (waddr_i == raddr_i);
    idx      = raddr_i[IDX_W-1:0];
    dout_d   = '0;
    if (in_range && !is_zero) begin
      dout_d = byp_hit ? wdata_i : mem_i[idx];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dout_q <= '0;
    end else if (ren_i) begin
      dout_q <= dout_d;
    end
  end

  assign dout_o = dout_q;

endmodule

// File: rtl/reg_file_2r1w.sv
// General-purpose register file, two registered read ports and one write port.
// REG_FILE_ZERO_REG_EN hardwires entry 0 to zero (no storage flops for it).
module reg_file_2r1w
  import cpu_pkg::*;
#(
  parameter int DATA_W   = CPU_DATA_W,
  parameter int ADDR_W   = CPU_ADDR_W,
  parameter int NUM_REGS = CPU_NUM_REGS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              ren_a,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] dout_a,
  input  logic              ren_b,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] dout_b
);

`ifdef REG_FILE_ZERO_REG_EN
  localparam int FIRST_REG = 1;
`else
  localparam int FIRST_REG = 0;
`endif

  logic [DATA_W-1:0] mem [NUM_REGS];

  // Out-of-range write addresses match no entry, so such writes drop naturally.
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    if (i < FIRST_REG) begin : g_zero
      assign mem[i] = '0;
    end else begin : g_flop
      logic [DATA_W-1:0] entry_q;
      logic [DATA_W-1:0] entry_d;

      assign entry_d = (we && (waddr == ADDR_W'(i))) ? wdata : entry_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          entry_q <= '0;
        end else begin
          entry_q <= entry_d;
        end
      end

      assign mem[i] = entry_q;
    end
  end

  reg_file_rd_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_rd_a (
    .clk_i   (clk),
    .rst_i   (rst),
    .ren_i   (ren_a),
    .raddr_i (raddr_a),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .mem_i   (mem),
    .dout_o  (dout_a)
  );

  reg_file_rd_port #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_rd_b (
    .clk_i   (clk),
    .rst_i   (rst),
    .ren_i   (ren_b),
    .raddr_i (raddr_b),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .mem_i   (mem),
    .dout_o  (dout_b)
  );

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Scoreboard bench for reg_file_2r1w (NUM_REGS=24); honours REG_FILE_ZERO_REG_EN.
module tb_reg_file_2r1w;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        ren_a;
  logic [4:0]  raddr_a;
  logic [31:0] dout_a;
  logic        ren_b;
  logic [4:0]  raddr_b;
  logic [31:0] dout_b;

  typedef struct {
    int          cyc;
    bit          port_b;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  reg_file_2r1w #(.NUM_REGS(24)) dut (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .ren_a   (ren_a),
    .raddr_a (raddr_a),
    .dout_a  (dout_a),
    .ren_b   (ren_b),
    .raddr_b (raddr_b),
    .dout_b  (dout_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: outputs are compared on the falling edge after the targeted rising edge.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      logic [31:0] act;
      e   = sb.pop_front();
      act = e.port_b ? dout_b : dout_a;
      n_tests++;
      if (act !== e.val) begin
        n_fail++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.val);
      end
    end
  end

  task automatic drive(input logic r, input logic w, input logic [4:0] wa,
                       input logic [31:0] wd, input logic ea, input logic [4:0] ra,
                       input logic eb, input logic [4:0] rb);
    rst = r; we = w; waddr = wa; wdata = wd;
    ren_a = ea; raddr_a = ra; ren_b = eb; raddr_b = rb;
  endtask

  task automatic expect_a(input logic [31:0] v, input string name);
    exp_t e;
    e.cyc = cyc + 1; e.port_b = 1'b0; e.val = v; e.name = name;
    sb.push_back(e);
  endtask

  task automatic expect_b(input logic [31:0] v, input string name);
    exp_t e;
    e.cyc = cyc + 1; e.port_b = 1'b1; e.val = v; e.name = name;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] zexp;

  initial begin
`ifdef REG_FILE_ZERO_REG_EN
    zexp = 32'h0;
`else
    zexp = 32'h55;
`endif
    drive(1, 0, 0, 0, 1, 0, 1, 0);
    tick();
    expect_a(32'h0, "reset_a");
    expect_b(32'h0, "reset_b");
    tick();

    drive(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
    tick();
    // Reset with a read of r5 and a write to r8 in flight.
    drive(1, 1, 8, 32'h0000CAFE, 1, 5, 0, 0);
    expect_a(32'h0, "reset_over_read");
    expect_b(32'h0, "reset_dout_b");
    tick();
    drive(0, 0, 0, 0, 1, 5, 1, 8);
    expect_a(32'h0, "r5_cleared");
    expect_b(32'h0, "r8_write_discarded");
    tick();

    drive(0, 1, 3, 32'h12345678, 0, 0, 0, 0);
    expect_a(32'h0, "hold_a_during_write");
    tick();
    drive(0, 0, 0, 0, 1, 3, 0, 0);
    expect_a(32'h12345678, "basic_read_r3");
    tick();

    drive(0, 1, 7, 32'hA5A5A5A5, 1, 7, 1, 7);
    expect_a(32'hA5A5A5A5, "bypass_a");
    expect_b(32'hA5A5A5A5, "bypass_b");
    tick();

    drive(0, 1, 2, 32'h11, 0, 0, 0, 0);
    expect_a(32'hA5A5A5A5, "hold_a_after_bypass");
    expect_b(32'hA5A5A5A5, "hold_b_after_bypass");
    tick();
    drive(0, 0, 0, 0, 0, 0, 1, 2);
    expect_b(32'h11, "read_r2_first");
    tick();
    drive(0, 1, 2, 32'h22, 0, 0, 0, 9);
    expect_b(32'h11, "hold_b_over_write");
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 9);
    expect_b(32'h11, "hold_b_addr_change");
    tick();
    drive(0, 0, 0, 0, 0, 0, 1, 2);
    expect_b(32'h22, "read_r2_updated");
    tick();
    drive(0, 0, 0, 0, 0, 0, 1, 9);
    expect_b(32'h0, "read_r9_unwritten");
    tick();

    drive(0, 1, 6, 32'h66, 0, 0, 0, 0);
    tick();
    drive(0, 1, 23, 32'h23232323, 0, 0, 0, 0);
    tick();
    drive(0, 1, 30, 32'hFFFFFFFF, 1, 30, 0, 0);
    expect_a(32'h0, "oor_bypass_r30");
    tick();
    drive(0, 0, 0, 0, 1, 6, 1, 23);
    expect_a(32'h66, "r6_not_aliased");
    expect_b(32'h23232323, "last_reg_r23");
    tick();
    drive(0, 1, 24, 32'h0000BEEF, 1, 24, 1, 31);
    expect_a(32'h0, "oor_bypass_r24");
    expect_b(32'h0, "oor_read_r31");
    tick();

    drive(0, 1, 0, 32'h55, 1, 0, 0, 0);
    expect_a(zexp, "r0_bypass");
    tick();
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    expect_a(zexp, "r0_read");
    tick();

    drive(0, 0, 0, 0, 1, 3, 1, 3);
    expect_a(32'h12345678, "same_reg_a");
    expect_b(32'h12345678, "same_reg_b");
    tick();

    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached, expected completion");
    $fatal(1);
  end

endmodule
